// File: rtl/weight_updater_pkg.sv
// -----------------------------------------------------------------------------
// weight_updater_pkg
// Shared definitions for the backprop update path: the IDLE/CALC/DONE state
// encoding (common with the outer-product block) and elaboration-time sizing
// helpers used to dimension tile counters and cell indices.
// No ports.
// -----------------------------------------------------------------------------
package weight_updater_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit so that
    // degenerate single-tile counters still have a legal width.
    function automatic int log2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/weight_updater_sat_sub_cell.sv
// -----------------------------------------------------------------------------
// sat_sub_cell
// Combinational SGD update of one matrix cell: w_new = sat(w - (g >>> LR_SHIFT)).
// Ports:
//   w      in  WEIGHT_CELL_WIDTH  current weight (signed)
//   g      in  GRAD_CELL_WIDTH    gradient (signed)
//   w_new  out WEIGHT_CELL_WIDTH  updated, clamped weight
//   sat    out 1                  clamp was applied
// -----------------------------------------------------------------------------
module sat_sub_cell #(
    parameter int GRAD_CELL_WIDTH   = 8,
    parameter int WEIGHT_CELL_WIDTH = 8,
    parameter int LR_SHIFT          = 2
) (
    input  logic signed [WEIGHT_CELL_WIDTH-1:0] w,
    input  logic signed [GRAD_CELL_WIDTH-1:0]   g,
    output logic signed [WEIGHT_CELL_WIDTH-1:0] w_new,
    output logic                                sat
);

    localparam int GW = GRAD_CELL_WIDTH;
    localparam int WW = WEIGHT_CELL_WIDTH;
    // One guard bit above the wider operand so the difference never wraps.
    localparam int EW = ((GW > WW) ? GW : WW) + 1;

    localparam logic signed [EW-1:0] MAX_V = {{(EW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-WW+1){1'b1}}, {(WW-1){1'b0}}};

    function automatic logic out_of_range(input logic signed [EW-1:0] x);
        return (x > MAX_V) || (x < MIN_V);
    endfunction

    function automatic logic signed [WW-1:0] saturate(input logic signed [EW-1:0] x);
        if (x > MAX_V)      return MAX_V[WW-1:0];
        else if (x < MIN_V) return MIN_V[WW-1:0];
        else                return x[WW-1:0];
    endfunction

    logic signed [GW-1:0] delta;
    logic signed [EW-1:0] diff;

    // Arithmetic shift rounds toward -inf, so small negative gradients still
    // nudge the weight upward by one LSB.
    assign delta = g >>> LR_SHIFT;
    assign diff  = EW'(w) - EW'(delta);
    assign w_new = saturate(diff);
    assign sat   = out_of_range(diff);

endmodule

// File: rtl/weight_updater.sv
// -----------------------------------------------------------------------------
// weight_updater
// Applies one SGD step W_new = sat(W - (G >>> LR_SHIFT)) to a ROWS x COLS weight
// matrix, TILING_V x TILING_H cells per CALC cycle, and streams the result out.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   gradient / _valid / _ready       flattened gradient matrix, cell (r,c) at
//                                    [(r*COLS+c)*GRAD_CELL_WIDTH +: GRAD_CELL_WIDTH]
//   weights_in / _valid / _ready     current weights, same layout
//   weights_out / _valid / _ready    updated weights, same layout
//   error                            sticky saturation flag for this transaction
// -----------------------------------------------------------------------------
module weight_updater
    import weight_updater_pkg::*;
#(
    parameter int ROWS              = 5,
    parameter int COLS              = 5,
    parameter int GRAD_CELL_WIDTH   = 8,
    parameter int WEIGHT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int LR_SHIFT          = 2,
    parameter int TILING_H          = 1,
    parameter int TILING_V          = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ROWS*COLS*GRAD_CELL_WIDTH-1:0]   gradient,
    input  logic                                   gradient_valid,
    output logic                                   gradient_ready,
    input  logic [ROWS*COLS*WEIGHT_CELL_WIDTH-1:0] weights_in,
    input  logic                                   weights_in_valid,
    output logic                                   weights_in_ready,
    output logic [ROWS*COLS*WEIGHT_CELL_WIDTH-1:0] weights_out,
    output logic                                   weights_out_valid,
    input  logic                                   weights_out_ready,
    output logic                                   error
);

    localparam int GW         = GRAD_CELL_WIDTH;
    localparam int WW         = WEIGHT_CELL_WIDTH;
    localparam int CELLS      = ROWS * COLS;
    localparam int TILES_H    = ceil_div(COLS, TILING_H);
    localparam int TILES_V    = ceil_div(ROWS, TILING_V);
    localparam int TILE_CELLS = TILING_V * TILING_H;
    localparam int CH_W       = log2(TILES_H);
    localparam int CV_W       = log2(TILES_V);
    localparam int IDX_W      = log2(CELLS);

    // Both formats share the binary point, so the update needs no rescale;
    // only guard against a format with no integer bit left.
    if (FRACTION_WIDTH >= WW || FRACTION_WIDTH >= GW) begin : g_bad_fraction
        $error("FRACTION_WIDTH must leave at least one integer bit per cell");
    end

    state_t                  state;
    logic                    grad_set;
    logic                    w_set;
    logic                    out_valid;
    logic                    err_q;
    logic [CH_W-1:0]         counter_h;
    logic [CV_W-1:0]         counter_v;
    logic                    out_fire;
    logic                    any_sat;

    logic signed [GW-1:0]    grad_cell   [CELLS];
    logic signed [WW-1:0]    weight_cell [CELLS];
    logic signed [WW-1:0]    tile_new    [TILE_CELLS];
    logic [TILE_CELLS-1:0]   tile_flag;

    assign gradient_ready    = ~grad_set;
    assign weights_in_ready  = ~w_set;
    assign weights_out_valid = out_valid;
    assign error             = err_q;
    assign out_fire          = (state == DONE) && out_valid && weights_out_ready;
    assign any_sat           = |tile_flag;

    // Input/result buffers, one register set per matrix cell.
    for (genvar c = 0; c < CELLS; c++) begin : g_cell
        localparam int R = c / COLS;
        localparam int C = c % COLS;
        // Position of this cell inside whichever tile covers it.
        localparam int K = (R % TILING_V) * TILING_H + (C % TILING_H);

        logic signed [GW-1:0] g_q;
        logic signed [WW-1:0] w_q;
        logic signed [WW-1:0] res_q;
        logic                 hit;

        assign hit = (state == CALC)
                  && (counter_v == CV_W'(R / TILING_V))
                  && (counter_h == CH_W'(C / TILING_H));

        always_ff @(posedge clk) begin
            if (rst) begin
                g_q   <= '0;
                w_q   <= '0;
                res_q <= '0;
            end else begin
                if (gradient_valid && gradient_ready)
                    g_q <= gradient[c*GW +: GW];
                if (weights_in_valid && weights_in_ready)
                    w_q <= weights_in[c*WW +: WW];
                if (out_fire)
                    res_q <= '0;
                else if (hit)
                    res_q <= tile_new[K];
            end
        end

        assign grad_cell[c]            = g_q;
        assign weight_cell[c]          = w_q;
        assign weights_out[c*WW +: WW] = res_q;
    end

    // Datapath for the tile currently addressed by the counters.
    for (genvar tv = 0; tv < TILING_V; tv++) begin : g_tile_v
        for (genvar th = 0; th < TILING_H; th++) begin : g_tile_h
            localparam int K = tv * TILING_H + th;

            int               row;
            int               col;
            logic             in_range;
            logic [IDX_W-1:0] idx;
            logic             sat;

            assign row      = int'(counter_v) * TILING_V + tv;
            assign col      = int'(counter_h) * TILING_H + th;
            assign in_range = (row < ROWS) && (col < COLS);
            // Out-of-range tile slots read cell 0; their result is never
            // written and their saturation is masked below.
            assign idx      = in_range ? IDX_W'(row * COLS + col) : '0;

            sat_sub_cell #(
                .GRAD_CELL_WIDTH  (GW),
                .WEIGHT_CELL_WIDTH(WW),
                .LR_SHIFT         (LR_SHIFT)
            ) u_cell (
                .w    (weight_cell[idx]),
                .g    (grad_cell[idx]),
                .w_new(tile_new[K]),
                .sat  (sat)
            );

            assign tile_flag[K] = in_range && sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grad_set  <= 1'b0;
            w_set     <= 1'b0;
            out_valid <= 1'b0;
            err_q     <= 1'b0;
            counter_h <= '0;
            counter_v <= '0;
        end else begin
            if (gradient_valid && gradient_ready)
                grad_set <= 1'b1;
            if (weights_in_valid && weights_in_ready)
                w_set <= 1'b1;

            case (state)
                IDLE: begin
                    if (grad_set && w_set) begin
                        state     <= CALC;
                        counter_h <= '0;
                        counter_v <= '0;
                    end
                end
                CALC: begin
                    if (any_sat)
                        err_q <= 1'b1;
                    if (counter_h == CH_W'(TILES_H - 1)) begin
                        counter_h <= '0;
                        if (counter_v == CV_W'(TILES_V - 1)) begin
                            counter_v <= '0;
                            state     <= DONE;
                        end else begin
                            counter_v <= counter_v + CV_W'(1);
                        end
                    end else begin
                        counter_h <= counter_h + CH_W'(1);
                    end
                end
                DONE: begin
                    // Valid is registered one cycle after the last tile lands.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (weights_out_ready) begin
                        out_valid <= 1'b0;
                        err_q     <= 1'b0;
                        grad_set  <= 1'b0;
                        w_set     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_updater.sv
module tb_weight_updater;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int CW   = 8;
    localparam int MW   = ROWS * COLS * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] gradient;
    logic [MW-1:0] weights_in;
    logic          gv, wv, rdy, sel;

    logic [MW-1:0] out_a, out_b;
    logic          gr_a, gr_b, wr_a, wr_b, v_a, v_b, e_a, e_b;

    logic [MW-1:0] o_w;
    logic          o_v, o_e, o_gr, o_wr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [MW-1:0] w;
        logic          e;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign o_w  = sel ? out_b : out_a;
    assign o_v  = sel ? v_b   : v_a;
    assign o_e  = sel ? e_b   : e_a;
    assign o_gr = sel ? gr_b  : gr_a;
    assign o_wr = sel ? wr_b  : wr_a;

    weight_updater #(
        .ROWS(ROWS), .COLS(COLS), .GRAD_CELL_WIDTH(CW), .WEIGHT_CELL_WIDTH(CW),
        .FRACTION_WIDTH(4), .LR_SHIFT(2), .TILING_H(1), .TILING_V(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .gradient(gradient), .gradient_valid(gv && !sel), .gradient_ready(gr_a),
        .weights_in(weights_in), .weights_in_valid(wv && !sel), .weights_in_ready(wr_a),
        .weights_out(out_a), .weights_out_valid(v_a), .weights_out_ready(rdy && !sel),
        .error(e_a)
    );

    weight_updater #(
        .ROWS(ROWS), .COLS(COLS), .GRAD_CELL_WIDTH(CW), .WEIGHT_CELL_WIDTH(CW),
        .FRACTION_WIDTH(4), .LR_SHIFT(2), .TILING_H(2), .TILING_V(1)
    ) u_tiled (
        .clk(clk), .rst(rst),
        .gradient(gradient), .gradient_valid(gv && sel), .gradient_ready(gr_b),
        .weights_in(weights_in), .weights_in_valid(wv && sel), .weights_in_ready(wr_b),
        .weights_out(out_b), .weights_out_valid(v_b), .weights_out_ready(rdy && sel),
        .error(e_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference: floor(g/4) via integer maths, then clamp to 8-bit signed.
    function automatic exp_t model(input logic [MW-1:0] g, input logic [MW-1:0] w);
        exp_t          r;
        logic [MW-1:0] gs, ws;
        byte           gb, wb;
        int            gi, wi, d, diff;
        r.w = '0;
        r.e = 1'b0;
        gs  = g;
        ws  = w;
        for (int c = 0; c < ROWS * COLS; c++) begin
            gb = gs[7:0];
            wb = ws[7:0];
            gs = gs >> 8;
            ws = ws >> 8;
            gi = gb;
            wi = wb;
            d  = (gi >= 0) ? gi / 4 : -((-gi + 3) / 4);
            diff = wi - d;
            if (diff > 127) begin
                diff = 127;
                r.e  = 1'b1;
            end else if (diff < -128) begin
                diff = -128;
                r.e  = 1'b1;
            end
            r.w = {diff[7:0], r.w[MW-1:CW]};
        end
        return r;
    endfunction

    task automatic run_txn(input string tag, input logic s, input logic [MW-1:0] g,
                           input logic [MW-1:0] w, input int stagger, input int stall,
                           input int n_tiles);
        exp_t e;
        int   cnt;
        logic done;
        sel = s;
        sb.push_back(model(g, w));
        gradient   = g;
        weights_in = w;
        if (stagger == 0) begin
            gv = 1'b1;
            wv = 1'b1;
            tick();
            gv = 1'b0;
            wv = 1'b0;
        end else begin
            gv = 1'b1;
            tick();
            gv = 1'b0;
            gradient = ~g;
            for (int i = 0; i < stagger - 1; i++) begin
                check({tag, "_gready_low"}, 64'(o_gr), 64'(0));
                tick();
            end
            wv = 1'b1;
            tick();
            wv = 1'b0;
        end
        // Post-capture input changes must not leak into the result.
        gradient   = ~g;
        weights_in = ~w;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 60) begin
            tick();
            cnt++;
            if (o_v) done = 1'b1;
            else if (stagger > 0) check({tag, "_gready_wait"}, 64'(o_gr), 64'(0));
        end
        check({tag, "_latency"}, 64'(cnt), 64'(n_tiles + 2));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard"}, 64'(0), 64'(1));
            e.w = '0;
            e.e = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_data"}, 64'(o_w), 64'(e.w));
        check({tag, "_error"}, 64'(o_e), 64'(e.e));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_valid"}, 64'(o_v), 64'(1));
            check({tag, "_stall_data"}, 64'(o_w), 64'(e.w));
            check({tag, "_stall_gready"}, 64'(o_gr), 64'(0));
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check({tag, "_valid_drop"}, 64'(o_v), 64'(0));
        check({tag, "_gready_rise"}, 64'(o_gr), 64'(1));
        check({tag, "_wready_rise"}, 64'(o_wr), 64'(1));
    endtask

    initial begin
        rst        = 1'b1;
        gv         = 1'b0;
        wv         = 1'b0;
        rdy        = 1'b0;
        sel        = 1'b0;
        gradient   = '0;
        weights_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_data",   64'(out_a), 64'(0));
        check("reset_valid",  64'(v_a),   64'(0));
        check("reset_error",  64'(e_a),   64'(0));
        check("reset_gready", 64'(gr_a),  64'(1));
        check("reset_wready", 64'(wr_a),  64'(1));

        // Basic update, both inputs in the same cycle.
        run_txn("t1", 1'b0, 48'h202020202020, 48'h101010101010, 0, 0, 6);
        // Arithmetic shift of small negative gradients.
        run_txn("t2", 1'b0, 48'hF8FF0400F8FF, 48'h101010101010, 0, 0, 6);
        // Positive and negative saturation, then a clean transaction.
        run_txn("t3a", 1'b0, 48'h808080808080, 48'h7F7F7F7F7F7F, 0, 0, 6);
        run_txn("t3b", 1'b0, 48'h7F7F7F7F7F7F, 48'h808080808080, 0, 0, 6);
        run_txn("t3c", 1'b0, 48'h202020202020, 48'h101010101010, 0, 0, 6);
        // Staggered inputs and a stalled output.
        run_txn("t4", 1'b0, 48'h40C010F01C04, 48'h05F030E0007F, 5, 10, 6);
        // Two-column tiles with an out-of-range slot.
        run_txn("t5", 1'b1, 48'h202020202020, 48'h101010101010, 0, 0, 4);
        run_txn("t5b", 1'b1, 48'h80F8047F0010, 48'h7F10F0807F00, 0, 0, 4);

        // Reset in the third CALC cycle.
        sel        = 1'b0;
        gradient   = 48'h202020202020;
        weights_in = 48'h7F7F7F7F7F7F;
        gv = 1'b1;
        wv = 1'b1;
        tick();
        gv = 1'b0;
        wv = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid",  64'(o_v),  64'(0));
        check("t6_error",  64'(o_e),  64'(0));
        check("t6_data",   64'(o_w),  64'(0));
        check("t6_gready", 64'(o_gr), 64'(1));
        check("t6_wready", 64'(o_wr), 64'(1));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_valid", 64'(o_v), 64'(0));
        end
        run_txn("t6_fresh", 1'b0, 48'hFF0102FE7FC0, 48'h102030405060, 0, 2, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
